// File: rtl/pll_pkg.sv
// Shared constants and elaboration-time helpers for the tracking PLL:
// LUT geometry, signed saturation and the quarter-wave sine generator.
package pll_pkg;

    localparam int unsigned LUT_AW    = 10;
    localparam int unsigned LUT_DEPTH = 1 << LUT_AW;
    localparam int unsigned QTR_DEPTH = LUT_DEPTH / 4;

    // pi in Q30, used only to build the ROM contents at elaboration
    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                                 input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // amp * sin(pi*k/512) for k in 0..256, Taylor series in Q30, rounded
    function automatic longint qsin(input longint k, input longint amp);
        longint x;
        longint term;
        longint sum;
        longint res;
        x    = (k * PI_Q30) / 512;
        term = x;
        sum  = x;
        for (int unsigned n = 1; n < 8; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        res = (sum * amp + (64'sd1 <<< 29)) >>> 30;
        if (res > amp) res = amp;
        if (res < 0)   res = 0;
        return res;
    endfunction

endpackage

// File: rtl/pll_sincos_lut.sv
// Registered quarter-wave sin/cos lookup, one clock of latency.
// Index 0 gives cos=+max, sin=0; index 256 gives cos=0, sin=+max.
module pll_sincos_lut
    import pll_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [LUT_AW-1:0]   idx_i,
    output logic signed [W-1:0] sin_o,
    output logic signed [W-1:0] cos_o
);

    localparam longint AMP = (longint'(1) <<< (W - 1)) - 1;

    logic signed [W-1:0] qrom [QTR_DEPTH + 1];

    for (genvar k = 0; k <= int'(QTR_DEPTH); k++) begin : g_rom
        localparam logic signed [W-1:0] V = W'(qsin(longint'(k), AMP));
        assign qrom[k] = V;
    end

    logic [1:0]          quad;
    logic [7:0]          r;
    logic signed [W-1:0] fwd;
    logic signed [W-1:0] rev;
    logic signed [W-1:0] sin_d;
    logic signed [W-1:0] cos_d;

    always_comb begin
        quad  = idx_i[LUT_AW-1 -: 2];
        r     = idx_i[LUT_AW-3:0];
        fwd   = qrom[{1'b0, r}];
        rev   = qrom[9'(QTR_DEPTH) - {1'b0, r}];
        sin_d = '0;
        cos_d = '0;
        case (quad)
            2'd0: begin sin_d =  fwd; cos_d =  rev; end
            2'd1: begin sin_d =  rev; cos_d = -fwd; end
            2'd2: begin sin_d = -fwd; cos_d = -rev; end
            default: begin sin_d = -rev; cos_d =  fwd; end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sin_o <= '0;
            cos_o <= '0;
        end else begin
            sin_o <= sin_d;
            cos_o <= cos_d;
        end
    end

endmodule

// File: rtl/tracking_pll.sv
// Sampled tracking PLL: NCO + sin/cos LUT, mixer phase detector,
// PI loop filter with saturating integrator, and lock detector.
module tracking_pll
    import pll_pkg::*;
#(
    parameter int unsigned       W           = 16,
    parameter int unsigned       ACC_W       = 32,
    parameter logic [ACC_W-1:0]  FCW0        = ACC_W'(32'h0100_0000),
    parameter int unsigned       KP_SHIFT    = 8,
    parameter int unsigned       KI_SHIFT    = 2,
    parameter int unsigned       LOCK_THRESH = 1024,
    parameter int unsigned       LOCK_COUNT  = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 loop_en_i,
    input  logic signed [W-1:0]  signal_i,
    output logic signed [W-1:0]  signal_o,
    output logic signed [W-1:0]  phase_o,
    output logic [ACC_W-1:0]     freq_o,
    output logic                 lock_o,
    output logic                 valid_o,
    output logic                 overrun_o
);

    localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

    logic                    v1_q, v2_q, v3_q, valid_q, overrun_q, lock_q;
    logic [LUT_AW-1:0]       idx_q;
    logic signed [W-1:0]     sig1_q, sig2_q, err_q, cos2_q, signal_q, phase_q;
    logic [ACC_W-1:0]        acc_q, freq_q;
    logic signed [ACC_W-1:0] integ_q;
    logic [CW-1:0]           cnt_q;

    logic signed [W-1:0]     lut_sin, lut_cos, neg_sin, err_d;
    logic signed [2*W-1:0]   prod;
    logic                    busy, accept;

    pll_sincos_lut #(.W(W)) u_lut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .idx_i (idx_q),
        .sin_o (lut_sin),
        .cos_o (lut_cos)
    );

    assign busy   = v1_q | v2_q | v3_q;
    assign accept = tick_i & ~busy;

    always_comb begin
        neg_sin = -lut_sin;
        prod    = (2*W)'(sig2_q) * (2*W)'(neg_sin);
        err_d   = W'(sat_s(64'(prod >>> (W - 1)), W));
    end

    logic signed [ACC_W-1:0] err_ext, kp_term, ki_term, integ_d;
    logic [ACC_W-1:0]        freq_d;
    logic                    in_lock, lock_d;
    logic [CW-1:0]           cnt_d;

    always_comb begin
        err_ext = ACC_W'(err_q);
        kp_term = err_ext <<< KP_SHIFT;
        ki_term = err_ext <<< KI_SHIFT;
        integ_d = ACC_W'(sat_s(64'(integ_q) + 64'(ki_term), ACC_W));
        freq_d  = FCW0 + $unsigned(kp_term) + $unsigned(integ_d);
        in_lock = (int'(err_q) < int'(LOCK_THRESH)) && (int'(err_q) > -int'(LOCK_THRESH));
        cnt_d   = '0;
        if (!loop_en_i) begin
            integ_d = '0;
            freq_d  = FCW0;
        end else if (in_lock) begin
            cnt_d = (cnt_q == CW'(LOCK_COUNT)) ? cnt_q : cnt_q + 1'b1;
        end
        lock_d = (cnt_d == CW'(LOCK_COUNT));
    end

    // Stage valids double as the busy window; reset drops any in-flight sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            idx_q     <= '0;
            sig1_q    <= '0;
            sig2_q    <= '0;
            err_q     <= '0;
            cos2_q    <= '0;
        end else begin
            v1_q      <= accept;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            valid_q   <= v3_q;
            overrun_q <= overrun_q | (tick_i & busy);
            if (accept) begin
                idx_q  <= acc_q[ACC_W-1 -: LUT_AW];
                sig1_q <= signal_i;
            end
            if (v1_q) sig2_q <= sig1_q;
            if (v2_q) begin
                err_q  <= err_d;
                cos2_q <= lut_cos;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            integ_q  <= '0;
            cnt_q    <= '0;
            lock_q   <= 1'b0;
            freq_q   <= '0;
            signal_q <= '0;
            phase_q  <= '0;
        end else if (v3_q) begin
            acc_q    <= acc_q + freq_d;
            integ_q  <= integ_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            freq_q   <= freq_d;
            signal_q <= cos2_q;
            phase_q  <= err_q;
        end
    end

    assign signal_o  = signal_q;
    assign phase_o   = phase_q;
    assign freq_o    = freq_q;
    assign lock_o    = lock_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: doc/tracking_pll.md
TRACKING_PLL -- requirements
Module: tracking_pll

Interface
REQ-001 Parameter W, default 16: signal/phase sample width, signed.
REQ-002 Parameter ACC_W, default 32: NCO phase-accumulator and frequency-word width.
REQ-003 Parameter FCW0, default 32'h0100_0000: centre frequency word, unsigned.
REQ-004 Parameter KP_SHIFT, default 8: proportional gain, left shift applied to phase error.
REQ-005 Parameter KI_SHIFT, default 2: integral gain, left shift applied to phase error.
REQ-006 Parameter LOCK_THRESH, default 1024: |phase error| bound for in-lock sample.
REQ-007 Parameter LOCK_COUNT, default 256: consecutive in-lock samples required to assert lock.
REQ-008 clk_i  in  1  single system clock, all logic rising-edge.
REQ-009 rst_i  in  1  reset, asynchronous, active-high.
REQ-010 tick_i  in  1  sample strobe, one clk_i wide.
REQ-011 loop_en_i  in  1  1 = closed loop, 0 = free-run at FCW0.
REQ-012 signal_i  in  W  signed input sample, sampled on tick_i.
REQ-013 signal_o  out  W  signed cosine local-oscillator sample.
REQ-014 phase_o  out  W  signed phase-error sample.
REQ-015 freq_o  out  ACC_W  frequency word applied on latest update.
REQ-016 lock_o  out  1  lock indication.
REQ-017 valid_o  out  1  one-cycle pulse, outputs updated.
REQ-018 overrun_o  out  1  sticky, tick arrived while busy.

Function
REQ-019 Pipeline: tick cycle T captures signal_i and accumulator top 10 bits; T+1 registered sin/cos LUT read; T+2 mix; T+3 loop update, outputs updated, valid_o=1 for exactly one cycle.
REQ-020 Block busy from T to T+3 inclusive; tick_i while busy ignored, overrun_o set to 1, held until reset.
REQ-021 LUT amplitude 2^(W-1)-1; phase index 0 gives cos=+max, sin=0; index 256 gives cos=0, sin=+max.
REQ-022 Phase error = (signal_i * -sin) arithmetic-shifted right W-1, full-precision product, result saturated to W bits.
REQ-023 Integrator, ACC_W signed: integ += sign-extended (err <<< KI_SHIFT), saturated at signed ACC_W limits, no wrap.
REQ-024 freq = FCW0 + (err <<< KP_SHIFT) + integ, modulo 2^ACC_W; accumulator += freq, modulo 2^ACC_W, wrap-around intended.
REQ-025 loop_en_i=0 at T+3: integ forced to 0, freq = FCW0, phase_o still computed.
REQ-026 Lock counter: |err| < LOCK_THRESH increments counter, saturating at LOCK_COUNT; otherwise counter cleared and lock_o=0.
REQ-027 lock_o=1 when counter reaches LOCK_COUNT; loop_en_i=0 clears counter and lock_o.
REQ-028 signal_o = cosine sample used at T+2; phase_o = err; freq_o = freq applied at T+3.
REQ-029 Counter and integrator update only on valid_o cycles.

Reset
REQ-030 rst_i=1 asynchronously clears accumulator, integrator, lock counter, pipeline valid bits, all outputs to 0.
REQ-031 Reset mid-pipeline discards in-flight sample; no valid_o after release until a new tick_i.
REQ-032 First tick after release uses accumulator phase 0.

Structure
REQ-033 Package pll_pkg holds LUT_AW=10, LUT depth constant, saturation helper functions.
REQ-034 One sub-module pll_sincos_lut: registered quarter-wave sin/cos lookup, one-cycle latency.
REQ-035 No other sub-modules; mixer and loop filter inline.

Verification
REQ-036 loop_en_i=0, FCW0=32'h4000_0000, signal_i=0, ticks every 8 clocks -> signal_o 32767,0,-32767,0 repeating, phase_o=0, freq_o=32'h4000_0000.
REQ-037 Two ticks 2 clocks apart -> one valid_o only, overrun_o=1 until rst_i.
REQ-038 loop_en_i=1, signal_i=+32767 constant, KI_SHIFT=2 -> integ rises, clamps at 2^31-1, never wraps negative.
REQ-039 Input cosine at FCW0, loop_en_i=1 -> lock_o=1 exactly at valid_o #LOCK_COUNT; one |err|>=LOCK_THRESH sample -> lock_o=0 next valid_o.
REQ-040 rst_i pulse at T+1 -> no valid_o, all outputs 0, next tick output matches REQ-032.
REQ-041 loop_en_i toggled 1->0 while locked -> lock_o=0, freq_o=FCW0 on next valid_o.
